// File: rtl/mac_vec_engine.sv
// Sequential multiply-accumulate over len operand pairs (a*b summed into an ACC_W accumulator).
// Latency: 3 cycles per term plus one DONE cycle; done arrives 3*len+1 cycles after go.
// Backpressure: in_ready is high only in FETCH; in_valid low there stalls the engine cycle-for-cycle.
module mac_vec_engine #(
  parameter int DATA_W   = 8,
  parameter int LEN_W    = 8,
  parameter int ACC_W    = 2*DATA_W+LEN_W,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic              ovf
);

  localparam int PW = 2*DATA_W;

  generate
    if (ACC_W < 2*DATA_W) begin : g_bad_acc_w
      $error("mac_vec_engine: ACC_W must be at least 2*DATA_W");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MULT  = 3'd2,
    S_ACCUM = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q;
  logic [ACC_W-1:0]    acc_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [PW-1:0]       prod_q;
  logic [ACC_W-1:0]    result_q;
  logic                ovf_q;
  logic                busy_q;
  logic                done_q;
  logic                rdy_q;

  logic [PW-1:0]       prod_d;
  logic [ACC_W-1:0]    ext_d;
  logic [ACC_W-1:0]    sum_d;
  logic                carry_d;
  logic                ovf_hit_d;
  logic [ACC_W-1:0]    acc_d;

  localparam logic [ACC_W-1:0] UMAX = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Product, operand extension, accumulate sum with overflow detection and optional clamp
  always_comb begin
    prod_d    = '0;
    ext_d     = '0;
    sum_d     = '0;
    carry_d   = 1'b0;
    ovf_hit_d = 1'b0;
    acc_d     = '0;
    if (SIGNED != 0) begin
      prod_d = PW'($signed(a_q)) * PW'($signed(b_q));
      ext_d  = ACC_W'($signed(prod_q));
    end else begin
      prod_d = PW'(a_q) * PW'(b_q);
      ext_d  = ACC_W'(prod_q);
    end
    {carry_d, sum_d} = {1'b0, acc_q} + {1'b0, ext_d};
    if (SIGNED != 0) begin
      // Signed overflow: both addends share a sign that the sum does not
      ovf_hit_d = (acc_q[ACC_W-1] == ext_d[ACC_W-1]) && (sum_d[ACC_W-1] != acc_q[ACC_W-1]);
    end else begin
      ovf_hit_d = carry_d;
    end
    acc_d = sum_d;
    if (ovf_hit_d && (SATURATE != 0)) begin
      if (SIGNED != 0) begin
        acc_d = acc_q[ACC_W-1] ? SMIN : SMAX;
      end else begin
        acc_d = UMAX;
      end
    end
  end

  // Control FSM with datapath registers and registered Moore outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (len != '0) begin
              cnt_q   <= len;
              rdy_q   <= 1'b1;
              state_q <= S_FETCH;
            end else begin
              cnt_q    <= '0;
              result_q <= '0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          if (in_valid) begin
            a_q     <= a_in;
            b_q     <= b_in;
            rdy_q   <= 1'b0;
            state_q <= S_MULT;
          end
        end
        S_MULT: begin
          prod_q  <= prod_d;
          state_q <= S_ACCUM;
        end
        S_ACCUM: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (ovf_hit_d) begin
            ovf_q <= 1'b1;
          end
          if (cnt_q == LEN_W'(1)) begin
            result_q <= acc_d;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            rdy_q   <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          rdy_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready = rdy_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign ovf      = ovf_q;

endmodule
